// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit: iterative MULT/MULTU/DIV/DIVU into HI/LO,
// plus MFHI/MFLO/MTHI/MTLO service and hazard stall request.
module hilo_muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    input  logic [5:0]  funct,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data
);

    localparam logic [5:0] F_MFHI = 6'b010000;
    localparam logic [5:0] F_MTHI = 6'b010001;
    localparam logic [5:0] F_MTLO = 6'b010011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t      state;
    state_t      nxt;
    logic [63:0] p;
    logic [31:0] opnd;
    logic [5:0]  cnt;
    logic        op_div;
    logic        qneg;
    logic        rneg;
    logic        dz;

    logic        is_md;
    logic        is_hilo;
    logic        sgn;
    logic        accept;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [32:0] msum;
    logic [63:0] mul_next;
    logic [33:0] dtrial;
    logic [63:0] div_next;
    logic [63:0] prod;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] res_hi;
    logic [31:0] res_lo;

    // Decode, operand magnitudes and handshake outputs
    always_comb begin
        is_md     = (funct[5:2] == 4'b0110);
        is_hilo   = is_md || (funct[5:2] == 4'b0100);
        sgn       = ~funct[0];
        busy      = (state != S_IDLE);
        stall_req = op_valid & is_hilo & busy;
        accept    = op_valid & is_md & ~flush & (state == S_IDLE);
        a_mag     = (sgn && rs_data[31]) ? -rs_data : rs_data;
        b_mag     = (sgn && rt_data[31]) ? -rt_data : rt_data;
        mf_data   = (funct == F_MFHI) ? hi : lo;
    end

    // One shift-add / restoring-divide step and the sign fix-up result
    always_comb begin
        msum     = {1'b0, p[63:32]} + (p[0] ? {1'b0, opnd} : 33'd0);
        mul_next = {msum, p[31:1]};
        dtrial   = {1'b0, p[63:31]} - {2'b00, opnd};
        div_next = dtrial[33] ? {p[62:0], 1'b0}
                              : {dtrial[31:0], p[30:0], 1'b1};
        prod     = qneg ? -p : p;
        quo      = qneg ? -p[31:0] : p[31:0];
        rem      = rneg ? -p[63:32] : p[63:32];
        res_hi   = op_div ? rem : prod[63:32];
        res_lo   = op_div ? (dz ? 32'hFFFF_FFFF : quo) : prod[31:0];
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        nxt = state;
        unique case (state)
            S_IDLE: if (accept) nxt = funct[1] ? S_DIV : S_MUL;
            S_MUL:  if (cnt == 6'd1) nxt = S_FIX;
            S_DIV:  if (cnt == 6'd1) nxt = S_FIX;
            S_FIX:  nxt = S_IDLE;
        endcase
        if (flush) nxt = S_IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= nxt;
    end

    // Datapath: operand latch, iterations, HI/LO writes, done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p      <= '0;
            opnd   <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            dz     <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                cnt <= '0;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if (accept) begin
                            op_div <= funct[1];
                            opnd   <= funct[1] ? b_mag : a_mag;
                            p      <= {32'd0, funct[1] ? a_mag : b_mag};
                            qneg   <= sgn & (rs_data[31] ^ rt_data[31]);
                            rneg   <= sgn & rs_data[31];
                            dz     <= (rt_data == 32'd0);
                            cnt    <= 6'd32;
                        end else if (op_valid && funct == F_MTHI) begin
                            hi <= rs_data;
                        end else if (op_valid && funct == F_MTLO) begin
                            lo <= rs_data;
                        end
                    end
                    S_MUL: begin
                        p   <= mul_next;
                        cnt <= cnt - 6'd1;
                    end
                    S_DIV: begin
                        p   <= div_next;
                        cnt <= cnt - 6'd1;
                    end
                    S_FIX: begin
                        hi   <= res_hi;
                        lo   <= res_lo;
                        done <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// tb_hilo_muldiv_unit: vector table, random ops vs. arithmetic model,
// and hand sequences for stall, flush, back-to-back and async reset.
module tb_hilo_muldiv_unit;

    localparam logic [5:0] MFHI  = 6'b010000;
    localparam logic [5:0] MTHI  = 6'b010001;
    localparam logic [5:0] MFLO  = 6'b010010;
    localparam logic [5:0] MTLO  = 6'b010011;
    localparam logic [5:0] MULT  = 6'b011000;
    localparam logic [5:0] MULTU = 6'b011001;
    localparam logic [5:0] DIV   = 6'b011010;
    localparam logic [5:0] DIVU  = 6'b011011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [31:0] rs_data = 32'd0;
    logic [31:0] rt_data = 32'd0;
    logic        flush = 1'b0;
    logic        busy;
    logic        done;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] mf_data;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] eh;
        logic [31:0] el;
    } vec_t;

    vec_t tbl[7];

    hilo_muldiv_unit dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .funct     (funct),
        .rs_data   (rs_data),
        .rt_data   (rt_data),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic [5:0] f,
                                  input logic [31:0] a,
                                  input logic [31:0] b,
                                  output logic [31:0] h,
                                  output logic [31:0] l);
        longint      sa;
        longint      sb;
        logic [63:0] r64;
        logic [63:0] q64;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        h = 32'd0;
        l = 32'd0;
        case (f)
            MULT: begin
                r64 = 64'(sa * sb);
                h = r64[63:32];
                l = r64[31:0];
            end
            MULTU: begin
                r64 = {32'd0, a} * {32'd0, b};
                h = r64[63:32];
                l = r64[31:0];
            end
            DIV: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    q64 = 64'(sa / sb);
                    r64 = 64'(sa % sb);
                    h = r64[31:0];
                    l = q64[31:0];
                end
            end
            default: begin
                if (b == 0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    h = a % b;
                    l = a / b;
                end
            end
        endcase
    endfunction

    task automatic start_op(input logic [5:0] f, input logic [31:0] a,
                            input logic [31:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        funct = f;
        rs_data = a;
        rt_data = b;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        funct = 6'd0;
    endtask

    // n: negedge index of done (-1 if none); bc/dc: busy/done counts
    task automatic wait_done(output int n, output int bc, output int dc);
        n = -1;
        bc = 0;
        dc = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) dc++;
            if (done && n < 0) n = i;
            if (n > 0 && i >= n + 2) break;
        end
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] v);
        @(negedge clk);
        op_valid = 1'b1;
        funct = f;
        rs_data = v;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        funct = 6'd0;
    endtask

    task automatic run_chk(input string nm, input logic [5:0] f,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el,
                           input bit tm);
        int n;
        int bc;
        int dc;
        start_op(f, a, b);
        wait_done(n, bc, dc);
        chk({nm, " hi"}, hi, eh);
        chk({nm, " lo"}, lo, el);
        if (tm) begin
            chk({nm, " done_at"}, n, 34);
            chk({nm, " busy_cyc"}, bc, 33);
            chk({nm, " done_cyc"}, dc, 1);
        end
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        int          n;
        int          bc;
        int          dc;
        int          seen;

        tbl[0] = '{MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                   32'hFFFF_FFFE, 32'h0000_0001};
        tbl[1] = '{MULT, 32'hFFFF_FFF9, 32'd3,
                   32'hFFFF_FFFF, 32'hFFFF_FFEB};
        tbl[2] = '{DIV, 32'hFFFF_FFF9, 32'd2,
                   32'hFFFF_FFFF, 32'hFFFF_FFFD};
        tbl[3] = '{DIVU, 32'd100, 32'd7, 32'd2, 32'd14};
        tbl[4] = '{DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF};
        tbl[5] = '{DIV, 32'h8000_0000, 32'hFFFF_FFFF,
                   32'd0, 32'h8000_0000};
        tbl[6] = '{DIV, 32'hFFFF_FFF0, 32'd0,
                   32'hFFFF_FFF0, 32'hFFFF_FFFF};

        #12;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst hi", hi, 0);
        chk("rst lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++)
            run_chk($sformatf("tbl%0d", i), tbl[i].f, tbl[i].a,
                    tbl[i].b, tbl[i].eh, tbl[i].el, 1'b1);

        for (int i = 0; i < 30; i++) begin
            f = MULT + 6'($urandom_range(0, 3));
            a = $urandom;
            case ($urandom_range(0, 3))
                0: b = 32'($urandom_range(0, 15));
                1: b = -32'($urandom_range(1, 15));
                default: b = $urandom;
            endcase
            model(f, a, b, eh, el);
            run_chk($sformatf("rnd%0d f=%b a=%h b=%h", i, f, a, b),
                    f, a, b, eh, el, 1'b0);
        end

        mt(MTLO, 32'hDEAD_0000);
        mt(MTHI, 32'h0BAD_F00D);
        @(negedge clk);
        chk("mtlo lo", lo, 32'hDEAD_0000);
        chk("mthi hi", hi, 32'h0BAD_F00D);
        funct = MFHI;
        #1;
        chk("mfhi data", mf_data, 32'h0BAD_F00D);
        funct = 6'd0;

        start_op(MULT, 32'd6, 32'd7);
        op_valid = 1'b1;
        funct = MFLO;
        seen = 0;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            if (stall_req) seen++;
            if (i == 1) chk("mf old lo", mf_data, 32'hDEAD_0000);
        end
        chk("stall cycles", seen, 33);
        @(negedge clk);
        chk("stall released", stall_req, 0);
        chk("mf new lo", mf_data, 32'd42);
        chk("mf done", done, 1);
        op_valid = 1'b0;
        funct = 6'd0;

        mt(MTLO, 32'h1111_2222);
        mt(MTHI, 32'h3333_4444);
        start_op(DIV, 32'd1000, 32'd3);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("flush no done", seen, 0);
        chk("flush busy", busy, 0);
        chk("flush hi", hi, 32'h3333_4444);
        chk("flush lo", lo, 32'h1111_2222);
        mt(MTHI, 32'h0000_1234);
        @(negedge clk);
        chk("mthi after flush", hi, 32'h0000_1234);
        chk("mthi busy", busy, 0);
        chk("mthi lo kept", lo, 32'h1111_2222);

        @(negedge clk);
        op_valid = 1'b1;
        funct = MULT;
        rs_data = 32'd9;
        rt_data = 32'd9;
        flush = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        funct = 6'd0;
        flush = 1'b0;
        @(negedge clk);
        chk("flush wins busy", busy, 0);
        chk("flush wins lo", lo, 32'h1111_2222);

        start_op(MULTU, 32'h0001_0000, 32'h0001_0000);
        n = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (done) begin
                n = i;
                break;
            end
        end
        chk("b2b first done_at", n, 34);
        chk("b2b first hi", hi, 32'd1);
        chk("b2b first lo", lo, 32'd0);
        op_valid = 1'b1;
        funct = DIVU;
        rs_data = 32'd1000;
        rt_data = 32'd9;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        funct = 6'd0;
        wait_done(n, bc, dc);
        chk("b2b second done_at", n, 34);
        chk("b2b second busy", bc, 33);
        chk("b2b second lo", lo, 32'd111);
        chk("b2b second hi", hi, 32'd1);

        start_op(MULT, 32'd5, 32'd9);
        repeat (5) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst hi", hi, 0);
        chk("arst lo", lo, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_chk("post rst multu", MULTU, 32'd2, 32'd3,
                32'd0, 32'd6, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv_unit.md
# hilo_muldiv_unit

Iterative multiply/divide unit in the execution stage, beside the ALU and fed by the same decoded R-type `funct` field. It executes MULT, MULTU, DIV and DIVU over multiple cycles into the architectural HI/LO registers. It also serves MFHI, MFLO, MTHI and MTLO, and raises a stall request so the pipeline holds any HI/LO-dependent instruction while an operation is in flight.

## Interface
- No parameters; the datapath width is fixed at 32 bits and the iteration count at 32.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `op_valid`  in  1  an R-type instruction with SPECIAL opcode is in EX this cycle.
- `funct`  in  6  instruction funct field.
- `rs_data`  in  32  rs operand (multiplicand / dividend / MT source).
- `rt_data`  in  32  rt operand (multiplier / divisor).
- `flush`  in  1  synchronous pipeline flush; aborts any in-flight operation.
- `busy`  out  1  a multiply or divide is in progress.
- `done`  out  1  one-cycle pulse; HI/LO were just written by a MULT/DIV.
- `stall_req`  out  1  combinational; EX must hold.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.
- `mf_data`  out  32  combinational; `hi` when funct=MFHI, otherwise `lo`.

## Operation
- Decoded funct values:
  - MFHI 010000, MTHI 010001, MFLO 010010, MTLO 010011.
  - MULT 011000, MULTU 011001, DIV 011010, DIVU 011011.
  - All other values are ignored.
- Any of these eight codes counts as a "HI/LO op".
- `stall_req` = `op_valid` & HI/LO op & `busy`.
- States:
  - IDLE.
  - MUL: 32 shift-add iterations on magnitudes.
  - DIV: 32 restoring-division iterations on magnitudes.
  - FIX: sign correction and HI/LO write.
- IDLE -> MUL/DIV on `op_valid` & mult/div funct & !`flush`.
  - Operands, signedness and result signs are latched at that edge.
- MUL/DIV -> FIX when the iteration counter reaches 0.
- FIX -> IDLE unconditionally.
- `flush` in any state -> IDLE next edge; HI/LO unchanged; no `done` pulse.
- Signed operations (MULT/DIV):
  - Operate on absolute values.
  - Product negated in FIX if rs[31]^rt[31].
  - Quotient negated if rs[31]^rt[31].
  - Remainder negated if rs[31].
- MULT/MULTU: HI = product[63:32], LO = product[31:0].
- DIV/DIVU: LO = quotient, HI = remainder.
- Divide by zero, signed or unsigned: LO = 32'hFFFFFFFF, HI = rs_data as latched; full latency still applies.
- DIV 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0.
- MTHI/MTLO in IDLE with `op_valid` & !`flush`: write rs_data into HI/LO at that edge; single cycle, `busy` stays 0.
- MT* while `busy`: stalled via `stall_req`, no write.
- MF* while `busy`: stalled; `mf_data` still shows the current, old HI/LO.
- A new mult/div is only accepted in IDLE; requests in other states are stalled, never queued.

## Timing
- Reset values:
  - `hi` = `lo` = 0.
  - `busy` = 0, `done` = 0.
  - State IDLE, counter 0.
- Reset takes effect immediately, mid-operation included; outputs follow asynchronously.
- Accept edge E0: `busy` = 1 from E0 through E33.
- Iteration edges E1..E32; the FIX edge is E33.
- At E33 HI/LO take the result, `busy` drops to 0 and `done` goes 1 for exactly one cycle.
- Latency: 33 cycles from accept to visible HI/LO.
- A stalled MF* in EX sees `stall_req` = 0 in the cycle after E33 and reads the new value that cycle.
- `done` and an MT* write cannot coincide, since MT* is stalled while `busy`.
- Back-to-back: a mult/div presented in the `done` cycle is accepted at that edge (no dead cycle).
- `flush` and accept in the same cycle: `flush` wins; nothing is accepted.

## Test plan
- Unsigned multiply:
  - Stimulus: MULTU 0xFFFFFFFF × 0xFFFFFFFF.
  - Response: after 33 cycles HI = 0xFFFFFFFE, LO = 0x00000001; `done` high exactly 1 cycle; `busy` high 33 cycles.
- Signed multiply and divide:
  - MULT -7 × 3: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB.
  - DIV -7 / 2: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
  - DIVU 100 / 7: LO = 14, HI = 2.
- Division corner cases:
  - DIVU 5 / 0: LO = 0xFFFFFFFF, HI = 5.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Hazard stalling:
  - Stimulus: MFLO issued on cycles 1..33 after MULT 6 × 7.
  - Response: `stall_req` = 1 each of those cycles; in the cycle after E33 `stall_req` = 0 and `mf_data` = 42.
- Flush, then move-to:
  - Stimulus: DIV started, `flush` at iteration 10, then MTHI 0x1234.
  - Response: after the flush HI/LO keep their old values and no `done`; MTHI writes HI = 0x1234 the next cycle with `busy` = 0.
- Async reset:
  - Stimulus: `rst_n` low mid-MULT, between edges.
  - Response: `busy`, `done`, `hi`, `lo` go to 0 immediately; after release a fresh MULTU 2 × 3 gives LO = 6.
